sbox_access_scheduler: RTL
==========================

// Module: sbox_access_scheduler
// PURPOSE
// - Shares one registered S-box ROM (1-cycle read latency; data 00 when not enabled)
//   between two requesters: round SubBytes (ST, 128-bit state) and AES-192 key expansion SubWord (KX, 32-bit).
// - Arbitrates, then streams one byte address per cycle to the ROM and reassembles the substituted word.
// - Returns the result with a one-cycle Done pulse. Sits between the round controller, the key schedule and the S-box ROM.
// PARAMETERS
// - ST_BYTES     16  bytes per ST request; ST_Data/ST_Result width = 8*ST_BYTES.
// - KX_BYTES     4   bytes per KX request; KX_Data/KX_Result width = 8*KX_BYTES.
// - KX_PRIORITY  0   0 = round-robin arbitration; 1 = KX always wins over ST.
// PORTS
// - CLK              in   1      system clock, all logic on posedge.
// - RST              in   1      synchronous, active-high reset.
// - ST_Req           in   1      SubBytes request; held high until ST_Done.
// - ST_Data          in   128    state to substitute; sampled in grant cycle only.
// - ST_Done          out  1      one-cycle pulse: ST_Result valid.
// - ST_Result        out  128    substituted state; held until next ST completion.
// - KX_Req           in   1      SubWord request; held high until KX_Done.
// - KX_Data          in   32     word to substitute; sampled in grant cycle only.
// - KX_Done          out  1      one-cycle pulse: KX_Result valid.
// - KX_Result        out  32     substituted word; held until next KX completion.
// - Rom_Read_Enable  out  1      S-box ROM read enable.
// - Rom_Read_Address out  8      S-box ROM byte address; 00 whenever enable is low.
// - Rom_Read_Data    in   8      S-box ROM data, valid one cycle after enable.
// - Busy             out  1      high in every state except IDLE.
// BEHAVIOUR
// - Reset: state=IDLE; all outputs 0; Last_Grant=ST (KX wins first tie); byte count and capture registers cleared.
// - FSM states and transitions:
//   - IDLE: if any Req, grant, load Data into shift reg, clear count -> ISSUE.
//   - ISSUE: assert enable; address = current MSB byte; shift; count++.
//     Captures ROM data from the previous ISSUE cycle. After N issues (N=ST_BYTES or KX_BYTES) -> DRAIN.
//   - DRAIN: enable low; capture last ROM byte -> DONE.
//   - DONE: write assembled word to granted Result; pulse granted Done; update Last_Grant -> IDLE.
// - Byte order: address sequence is Data[8N-1:8N-8] first, down to Data[7:0]. Result uses the same positions.
// - Latency (Req seen in IDLE at cycle 0): Done at cycle N+2. KX: cycle 6. ST: cycle 18.
//   Next grant is possible at cycle N+3.
// - Arbitration (KX_PRIORITY=0): both Req in IDLE -> grant the requester not in Last_Grant.
//   A single Req is granted immediately. No preemption once granted.
// - A Req asserted during Busy waits; it is evaluated on the next IDLE cycle.
// - Req dropped mid-operation: the operation still completes and Done still pulses.
// - Req still high in the cycle after Done: treated as a new request.
// - RST mid-operation: abort next cycle to IDLE; partial bytes discarded; no Done; Results cleared to 0.
// - Rom_Read_Data is ignored outside the ISSUE/DRAIN capture slots.
// STRUCTURE
// - Shared package aes_sbox_pkg holds:
//   - state encoding (IDLE/ISSUE/DRAIN/DONE);
//   - requester IDs REQ_ST/REQ_KX;
//   - BYTE_W=8 and the S-box ROM latency constant (=1).
// - Sub-module sbox_rr_arbiter: 2-way round-robin/fixed-priority grant with Last_Grant register.
// - Datapath: 128-bit shift reg, 5-bit byte counter, 128-bit capture reg, muxed result writeback.
// - Bench instantiates the real S-box ROM behind the ROM ports.
// TESTING
// - KX_Req with KX_Data=01020304 -> KX_Done at cycle 6, KX_Result=7C777BF2.
//   Addresses seen in order: 01, 02, 03, 04.
// - ST_Req with ST_Data=00112233445566778899AABBCCDDEEFF -> ST_Done at cycle 18,
//   ST_Result=638293C31BFC33F5C4EEACEA4BC12816.
// - ST_Req and KX_Req together after reset -> KX served first (KX_Done cycle 6), then ST (ST_Done cycle 25).
//   Repeated: grants alternate ST, KX.
// - KX_PRIORITY=1 with both held high continuously -> KX granted every time; ST never starves the bus.
//   Check KX_Done every 7 cycles.
// - RST asserted at cycle 8 of an ST operation -> IDLE next cycle, Busy=0, ST_Result=0, no ST_Done.
//   Rom_Read_Enable=0 and Rom_Read_Address=00.
// - KX_Req dropped at cycle 2 -> KX_Done still at cycle 6 with correct result.
//   No second operation is started.

Source files
------------

// File: rtl/aes_sbox_pkg.sv
// Shared definitions for the S-box access scheduler and its arbiter.
package aes_sbox_pkg;

  localparam int unsigned BYTE_W      = 8;
  // Registered ROM: data for an address appears this many cycles after the read.
  localparam int unsigned ROM_LATENCY = 1;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StDone
  } state_e;

  // Requester identifiers, also used as the grant encoding.
  localparam logic REQ_ST = 1'b0;
  localparam logic REQ_KX = 1'b1;

endpackage

// File: rtl/sbox_rr_arbiter.sv
// Two-way arbiter between SubBytes (ST) and SubWord (KX) requesters.
// Round-robin on ties, or fixed KX priority when KX_PRIORITY is set.
module sbox_rr_arbiter
  import aes_sbox_pkg::*;
#(
  parameter bit KX_PRIORITY = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic st_req,
  input  logic kx_req,
  input  logic update,
  input  logic update_id,
  output logic gnt
);

  logic last_q;

  // Remember the requester served last; reset value makes KX win the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= REQ_ST;
    end else if (update) begin
      last_q <= update_id;
    end
  end

  // Winner among the live requests; only consumed when at least one is high.
  always_comb begin
    gnt = REQ_ST;
    if (KX_PRIORITY) begin
      gnt = kx_req ? REQ_KX : REQ_ST;
    end else if (st_req && kx_req) begin
      gnt = (last_q == REQ_ST) ? REQ_KX : REQ_ST;
    end else if (kx_req) begin
      gnt = REQ_KX;
    end
  end

endmodule

// File: rtl/sbox_access_scheduler.sv
// Shares one registered S-box ROM between round SubBytes (ST) and key expansion
// SubWord (KX): arbitrates, streams one byte address per cycle, reassembles the result.
module sbox_access_scheduler
  import aes_sbox_pkg::*;
#(
  parameter int unsigned ST_BYTES    = 16,
  parameter int unsigned KX_BYTES    = 4,
  parameter bit          KX_PRIORITY = 1'b0
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       ST_Req,
  input  logic [BYTE_W*ST_BYTES-1:0] ST_Data,
  output logic                       ST_Done,
  output logic [BYTE_W*ST_BYTES-1:0] ST_Result,
  input  logic                       KX_Req,
  input  logic [BYTE_W*KX_BYTES-1:0] KX_Data,
  output logic                       KX_Done,
  output logic [BYTE_W*KX_BYTES-1:0] KX_Result,
  output logic                       Rom_Read_Enable,
  output logic [BYTE_W-1:0]          Rom_Read_Address,
  input  logic [BYTE_W-1:0]          Rom_Read_Data,
  output logic                       Busy
);

  localparam int unsigned SW = BYTE_W * ST_BYTES;
  localparam int unsigned KW = BYTE_W * KX_BYTES;

  state_e        state_q, state_d;
  logic [SW-1:0] shift_q;
  logic [SW-1:0] capture_q;
  logic [SW-1:0] st_result_q;
  logic [KW-1:0] kx_result_q;
  logic [4:0]    count_q;
  logic [4:0]    count_last;
  logic          gnt_q;
  logic          arb_gnt;
  logic          any_req;
  logic          last_issue;
  logic          capture_en;

  assign any_req    = ST_Req | KX_Req;
  assign count_last = (gnt_q == REQ_KX) ? 5'(KX_BYTES - 1) : 5'(ST_BYTES - 1);
  assign last_issue = (count_q == count_last);
  // The first issue has no ROM data behind it yet.
  assign capture_en = (count_q >= 5'(ROM_LATENCY));

  sbox_rr_arbiter #(
    .KX_PRIORITY (KX_PRIORITY)
  ) u_arbiter (
    .clk       (CLK),
    .rst       (RST),
    .st_req    (ST_Req),
    .kx_req    (KX_Req),
    .update    (state_q == StDone),
    .update_id (gnt_q),
    .gnt       (arb_gnt)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (any_req) state_d = StIssue;
      StIssue: if (last_issue) state_d = StDrain;
      StDrain: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    Rom_Read_Enable  = (state_q == StIssue);
    Rom_Read_Address = Rom_Read_Enable ? shift_q[SW-1 -: BYTE_W] : '0;
    Busy             = (state_q != StIdle);
    ST_Done          = (state_q == StDone) && (gnt_q == REQ_ST);
    KX_Done          = (state_q == StDone) && (gnt_q == REQ_KX);
  end

  // Datapath: load on grant, shift out addresses, shift in ROM bytes, write back in DRAIN.
  // KX data is left-aligned so the ROM address always comes from the top byte.
  always_ff @(posedge CLK) begin
    if (RST) begin
      shift_q     <= '0;
      capture_q   <= '0;
      count_q     <= '0;
      gnt_q       <= REQ_ST;
      st_result_q <= '0;
      kx_result_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            gnt_q     <= arb_gnt;
            shift_q   <= (arb_gnt == REQ_KX) ? (SW'(KX_Data) << (SW - KW)) : ST_Data;
            capture_q <= '0;
            count_q   <= '0;
          end
        end
        StIssue: begin
          shift_q <= shift_q << BYTE_W;
          count_q <= count_q + 5'd1;
          if (capture_en) capture_q <= {capture_q[SW-BYTE_W-1:0], Rom_Read_Data};
        end
        StDrain: begin
          if (gnt_q == REQ_KX) begin
            kx_result_q <= {capture_q[KW-BYTE_W-1:0], Rom_Read_Data};
          end else begin
            st_result_q <= {capture_q[SW-BYTE_W-1:0], Rom_Read_Data};
          end
        end
        default: ;
      endcase
    end
  end

  assign ST_Result = st_result_q;
  assign KX_Result = kx_result_q;

endmodule
